dec_scan_sequencer: RTL and testbench
=====================================

// Module: dec_scan_sequencer
// PURPOSE
//  Upstream driver for the 2-to-4 active-low decoder stage. Generates the 2-bit select
//  (sel_o[1] -> decoder A, sel_o[0] -> decoder B) and the active-low enable (en_n_o -> E).
//  Scans 0->1->2->3->0 with a programmable dwell time, or advances one address per step
//  press. Enforces break-before-make blanking: E is deasserted around every address change.
// PARAMETERS
//  DWELL_W   8   width of dwell_i; drive time per address = dwell_i+1 cycles
//  BLANK_CYC 2   cycles en_n_o is held high before each new address is driven (>=1)
// PORTS
//  clk      in   1        clock, single domain
//  rst_n    in   1        reset, asynchronous assert, active-low
//  ena      in   1        global enable; 0 = freeze all state, outputs hold
//  start_i  in   1        async pin, rising edge starts scanning
//  stop_i   in   1        async pin, rising edge returns to IDLE
//  mode_i   in   1        0 = auto scan, 1 = manual step (level, synchronised)
//  step_i   in   1        async pin, rising edge advances address in manual mode
//  dwell_i  in   DWELL_W  dwell count, quasi-static
//  sel_o    out  2        decoder address {A,B}
//  en_n_o   out  1        decoder enable, active-low (0 = a decoder output is active)
//  busy_o   out  1        1 whenever state != IDLE
//  wrap_o   out  1        1-cycle pulse when address wraps 3->0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sel_o=2'b00, en_n_o=1, busy_o=0, wrap_o=0,
//   counters=0, sync/edge flops=0. All outputs are registered.
//  Inputs: start_i/stop_i/step_i/mode_i pass through 2-flop synchronisers; rising-edge
//   detect on start/stop/step gives 1-cycle pulses. Pin high first sampled at edge k ->
//   FSM transitions at edge k+2.
//  FSM states: IDLE, BLANK, DRIVE.
//   IDLE : en_n_o=1. start pulse -> BLANK, sel_o=0, blank counter loaded BLANK_CYC-1.
//   BLANK: en_n_o=1 for exactly BLANK_CYC cycles, then -> DRIVE; dwell counter loads
//          dwell_i (sampled only on this transition).
//   DRIVE: en_n_o=0. Auto: after dwell_i+1 cycles -> BLANK with sel_o+1 (mod 4).
//          Manual: hold indefinitely; step pulse -> BLANK with sel_o+1 (mod 4).
//          sel_o changes only on the DRIVE->BLANK edge, never while en_n_o=0.
//  wrap_o: asserted for the single cycle after a 3->0 increment (registered with sel_o).
//  mode_i change takes effect at the next DRIVE decision; switching to auto mid-DRIVE
//   restarts nothing; the counter keeps running (in manual mode the counter is ignored).
//  Priority: stop > start > step. stop pulse in any state -> IDLE next edge, en_n_o=1,
//   sel_o retains last value. start while busy is ignored. step in auto mode or in
//   IDLE/BLANK is ignored (not queued).
//  dwell_i=0: DRIVE lasts 1 cycle. dwell_i=all-ones: 2^DWELL_W cycles; no overflow.
//  ena=0: no state, counter, sync or output change; pulses arriving are lost if pin
//   returns low while frozen (edge detect is also frozen, so a held level is seen later).
//  Reset mid-scan: immediate en_n_o=1, sel_o=0 asynchronously.
// STRUCTURE
//  Shared pkg: FSM state encoding (IDLE=2'd0, BLANK=2'd1, DRIVE=2'd2), sync depth const 2.
//  Sub-module: sync_edge_det (2-flop sync + rising-edge pulse, with ena, async rst_n),
//   instantiated three times; mode_i uses the same sync without the edge output.
//  Top: FSM, blank counter ($clog2(BLANK_CYC+1) bits), dwell counter (DWELL_W), sel reg.
// TESTING
//  T1 reset: rst_n=0 mid-DRIVE with sel_o=2 -> sel_o=0, en_n_o=1, busy_o=0 same cycle.
//  T2 auto scan: dwell_i=3, BLANK_CYC=2, start -> per address 2 cycles en_n_o=1 then
//   4 cycles en_n_o=0; sel_o 0,1,2,3,0; wrap_o one pulse at 3->0; period 24 cycles.
//  T3 manual: mode_i=1, start, 3 step presses -> sel_o 0->1->2->3, each preceded by
//   2 blank cycles; no advance without step over 100 cycles.
//  T4 priority: stop and start same cycle while in DRIVE -> IDLE, en_n_o=1, busy_o=0.
//  T5 edge dwell: dwell_i=0 -> en_n_o low exactly 1 cycle; dwell_i=8'hFF -> 256 cycles.
//  T6 ena=0 for 10 cycles mid-DRIVE -> outputs/counters frozen, scan resumes exactly.
//  All tests: assert en_n_o==1 on every cycle where sel_o changes (break-before-make).

Source files
------------

// File: rtl/dec_scan_sequencer_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM encoding,
// synchroniser depth and the address-advance helper.
package dec_scan_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    localparam int unsigned SYNC_DEPTH = 2;

    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/dec_scan_sequencer_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin with optional rising-edge
// pulse. All flops freeze while ena_i is low.
module sync_edge_det
    import dec_scan_sequencer_pkg::*;
#(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else if (ena_i) begin
            sync_q <= sync_d;
        end
    end

    assign level_o = sync_q[SYNC_DEPTH-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= 1'b0;
                end else if (ena_i) begin
                    prev_q <= level_o;
                end
            end

            // Pulse holds while frozen; the FSM is frozen too, so it acts once.
            assign rise_o = level_o & ~prev_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/dec_scan_sequencer.sv
// Scan sequencer driving the 2-to-4 active-low decoder: auto/manual address
// scan with break-before-make blanking of the enable around every change.
module dec_scan_sequencer
    import dec_scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL_W   = 8,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_i,
    input  logic               step_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [1:0]         sel_o,
    output logic               en_n_o,
    output logic               busy_o,
    output logic               wrap_o
);

    localparam int unsigned     BCW        = $clog2(BLANK_CYC + 1);
    localparam logic [BCW-1:0]  BLANK_LOAD = BCW'(BLANK_CYC - 1);

    logic start_p, stop_p, step_p, mode_s;
    logic start_lvl_unused, stop_lvl_unused, step_lvl_unused, mode_rise_unused;

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic               en_n_q, en_n_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic [BCW-1:0]     blank_cnt_q, blank_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               advance;

    sync_edge_det #(.EDGE_EN(1'b1)) u_sync_start (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_i   (ena),
        .d_i     (start_i),
        .level_o (start_lvl_unused),
        .rise_o  (start_p)
    );

    sync_edge_det #(.EDGE_EN(1'b1)) u_sync_stop (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_i   (ena),
        .d_i     (stop_i),
        .level_o (stop_lvl_unused),
        .rise_o  (stop_p)
    );

    sync_edge_det #(.EDGE_EN(1'b1)) u_sync_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_i   (ena),
        .d_i     (step_i),
        .level_o (step_lvl_unused),
        .rise_o  (step_p)
    );

    sync_edge_det #(.EDGE_EN(1'b0)) u_sync_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_i   (ena),
        .d_i     (mode_i),
        .level_o (mode_s),
        .rise_o  (mode_rise_unused)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        en_n_d      = en_n_q;
        busy_d      = busy_q;
        wrap_d      = 1'b0;
        blank_cnt_d = blank_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        advance     = 1'b0;

        if (stop_p) begin
            state_d = ST_IDLE;
            en_n_d  = 1'b1;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_p) begin
                        state_d     = ST_BLANK;
                        sel_d       = 2'd0;
                        blank_cnt_d = BLANK_LOAD;
                        en_n_d      = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt_q == '0) begin
                        state_d     = ST_DRIVE;
                        dwell_cnt_d = dwell_i;
                        en_n_d      = 1'b0;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    // Counter saturates so a manual hold cannot wrap it.
                    if (dwell_cnt_q != '0) begin
                        dwell_cnt_d = dwell_cnt_q - 1'b1;
                    end
                    advance = mode_s ? step_p : (dwell_cnt_q == '0);
                    if (advance) begin
                        state_d     = ST_BLANK;
                        sel_d       = next_sel(sel_q);
                        wrap_d      = (sel_q == 2'd3);
                        blank_cnt_d = BLANK_LOAD;
                        en_n_d      = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    en_n_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            en_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            blank_cnt_q <= '0;
            dwell_cnt_q <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            en_n_q      <= en_n_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
            blank_cnt_q <= blank_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign sel_o  = sel_q;
    assign en_n_o = en_n_q;
    assign busy_o = busy_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Scoreboard bench: each drive window (address, blanking before it, drive
// length, wrap pulses) is predicted from the scan rules and checked on output.
module tb_dec_scan_sequencer;

    localparam int DW = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          mode_i = 1'b0;
    logic          step_i = 1'b0;
    logic [DW-1:0] dwell_i = '0;
    logic [1:0]    sel_o;
    logic          en_n_o, busy_o, wrap_o;

    always #5 clk = ~clk;

    dec_scan_sequencer #(.DWELL_W(DW), .BLANK_CYC(BC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start_i (start_i),
        .stop_i  (stop_i),
        .mode_i  (mode_i),
        .step_i  (step_i),
        .dwell_i (dwell_i),
        .sel_o   (sel_o),
        .en_n_o  (en_n_o),
        .busy_o  (busy_o),
        .wrap_o  (wrap_o)
    );

    typedef struct {
        int sel;
        int blank;
        int drive;
        int wraps;
    } win_t;

    win_t exp_q[$];
    win_t cur, e;
    int   checks = 0;
    int   failures = 0;
    int   win_started = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: measures every drive window and pops the scoreboard.
    logic [1:0] prev_sel = 2'd0;
    logic       prev_en_n = 1'b1;
    logic       prev_wrap = 1'b0;
    int         blank_cnt = 0, drive_cnt = 0, wrap_cnt = 0;

    always @(negedge clk) begin
        if (sel_o !== prev_sel) chk("bbm_en_n_at_sel_change", int'(en_n_o), 1);
        if (wrap_o) chk("wrap_one_cycle", int'(prev_wrap), 0);
        if (!busy_o) begin
            chk("idle_en_n", int'(en_n_o), 1);
            blank_cnt = 0;
            drive_cnt = 0;
            wrap_cnt  = 0;
        end else if (en_n_o) begin
            if (!prev_en_n) begin
                cur.drive = drive_cnt;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("win_sel",   cur.sel,   e.sel);
                    chk("win_blank", cur.blank, e.blank);
                    chk("win_drive", cur.drive, e.drive);
                    chk("win_wrap",  cur.wraps, e.wraps);
                end
                blank_cnt = 0;
                wrap_cnt  = 0;
            end
            blank_cnt++;
            if (wrap_o) wrap_cnt++;
        end else begin
            if (prev_en_n) begin
                cur.sel   = int'(sel_o);
                cur.blank = blank_cnt;
                cur.wraps = wrap_cnt;
                drive_cnt = 0;
                win_started++;
            end
            drive_cnt++;
        end
        prev_sel  = sel_o;
        prev_en_n = en_n_o;
        prev_wrap = wrap_o;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        ticks(2);
        start_i = 1'b0;
    endtask

    task automatic do_stop();
        int n = 0;
        stop_i = 1'b1;
        ticks(2);
        stop_i = 1'b0;
        while (busy_o && n < 20) begin
            tick();
            n++;
        end
        chk("stop_reaches_idle", int'(busy_o), 0);
        ticks(4);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_win(input int target, input int budget);
        int n = 0;
        while (win_started < target && n < budget) begin
            tick();
            n++;
        end
        chk("window_start_seen", int'(win_started >= target), 1);
    endtask

    // Reference: auto scan visits 0,1,2,3,0.. each after BC blank cycles,
    // drives dwell+1 cycles, wraps on every return to 0 except the first.
    task automatic push_auto(input int n, input int d, input int freeze_k);
        win_t w;
        for (int k = 0; k < n; k++) begin
            w.sel   = k % 4;
            w.blank = BC;
            w.drive = d + 1 + ((k == freeze_k) ? 10 : 0);
            w.wraps = (k > 0 && (k % 4) == 0) ? 1 : 0;
            exp_q.push_back(w);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base, d, n, fk, r;
        int h[3];
        win_t w;
        logic [1:0] s_sel;
        logic s_en, s_busy;

        ticks(3);
        chk("rst_sel",  int'(sel_o),  0);
        chk("rst_en_n", int'(en_n_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_wrap", int'(wrap_o), 0);
        rst_n = 1'b1;
        ticks(2);

        // Auto scan, dwell 3; a step press mid-scan must be ignored.
        dwell_i = 8'd3;
        mode_i  = 1'b0;
        base = win_started;
        push_auto(9, 3, -1);
        pulse_start();
        wait_win(base + 2, 200);
        step_i = 1'b1;
        ticks(2);
        step_i = 1'b0;
        wait_empty("auto_d3_done", 400);
        do_stop();

        // Random dwell auto scans.
        repeat (3) begin
            d = int'($urandom_range(0, 12));
            n = int'($urandom_range(4, 9));
            dwell_i = DW'(d);
            push_auto(n, d, -1);
            pulse_start();
            wait_empty("auto_rand_done", 400);
            do_stop();
        end

        // Dwell extremes.
        dwell_i = 8'd0;
        push_auto(6, 0, -1);
        pulse_start();
        wait_empty("auto_d0_done", 200);
        do_stop();
        dwell_i = 8'hFF;
        push_auto(2, 255, -1);
        pulse_start();
        wait_empty("auto_dff_done", 1000);
        do_stop();

        // Freeze for 10 cycles inside a drive window.
        d  = int'($urandom_range(3, 9));
        fk = int'($urandom_range(1, 4));
        dwell_i = DW'(d);
        base = win_started;
        push_auto(6, d, fk);
        pulse_start();
        wait_win(base + fk + 1, 300);
        r = int'($urandom_range(0, d));
        ticks(r);
        s_sel = sel_o;
        s_en = en_n_o;
        s_busy = busy_o;
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("frozen_sel",  int'(sel_o),  int'(s_sel));
            chk("frozen_en_n", int'(en_n_o), int'(s_en));
            chk("frozen_busy", int'(busy_o), int'(s_busy));
        end
        ena = 1'b1;
        wait_empty("freeze_done", 400);
        do_stop();

        // Manual steps: pin high H ticks into a window ends it H+3 cycles in.
        mode_i  = 1'b1;
        dwell_i = DW'($urandom_range(0, 5));
        h[0] = 100;
        h[1] = int'($urandom_range(0, 10));
        h[2] = int'($urandom_range(0, 10));
        for (int k = 0; k < 3; k++) begin
            w.sel   = k;
            w.blank = BC;
            w.drive = h[k] + 3;
            w.wraps = 0;
            exp_q.push_back(w);
        end
        ticks(3);
        base = win_started;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_win(base + k + 1, 200);
            ticks(h[k]);
            step_i = 1'b1;
            ticks(2);
            step_i = 1'b0;
        end
        wait_empty("manual_done", 200);
        wait_win(base + 4, 50);
        chk("manual_sel3", int'(sel_o), 3);

        // Stop and start together while driving: stop wins.
        stop_i  = 1'b1;
        start_i = 1'b1;
        ticks(2);
        chk("stop_latency_busy", int'(busy_o), 1);
        stop_i  = 1'b0;
        start_i = 1'b0;
        tick();
        chk("stop_busy", int'(busy_o), 0);
        chk("stop_en_n", int'(en_n_o), 1);
        chk("stop_sel_kept", int'(sel_o), 3);
        ticks(5);
        chk("start_ignored", int'(busy_o), 0);
        mode_i = 1'b0;
        ticks(3);

        // Asynchronous reset while driving address 2.
        d = int'($urandom_range(2, 6));
        dwell_i = DW'(d);
        base = win_started;
        push_auto(2, d, -1);
        pulse_start();
        wait_empty("pre_reset_done", 200);
        wait_win(base + 3, 50);
        chk("pre_reset_sel", int'(sel_o), 2);
        chk("pre_reset_en_n", int'(en_n_o), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel",  int'(sel_o),  0);
        chk("async_rst_en_n", int'(en_n_o), 1);
        chk("async_rst_busy", int'(busy_o), 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
